// File: rtl/dtw_core_ref_loader.sv
// rtl/dtw_core_ref_loader.sv - streams a DTW reference template into sample memory.
// Optional running checksum output enabled by DTW_REF_LOADER_CHECKSUM_EN.
module dtw_core_ref_loader #(
  parameter int width  = 16,
  parameter int ptrWid = 15,
  parameter int depth  = 2**ptrWid
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ptrWid:0]   len,
  input  logic              s_valid,
  input  logic [width-1:0]  s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ptrWid-1:0] addrW,
  output logic              wren,
  output logic [width-1:0]  datain,
  output logic              busy,
  output logic              done,
  output logic [ptrWid:0]   ref_len,
  output logic              err
`ifdef DTW_REF_LOADER_CHECKSUM_EN
  ,
  output logic [width-1:0]  checksum
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [ptrWid:0] DEPTH_V = (ptrWid+1)'(depth);
  localparam logic [ptrWid:0] ONE     = (ptrWid+1)'(1);

  logic [1:0]      state;
  logic [ptrWid:0] len_q;
  logic [ptrWid:0] cnt;
  logic [ptrWid:0] cnt_nxt;
  logic            accept;
  logic            len_ok;

  // Handshake outputs come from state only, so s_ready never follows s_valid.
  assign s_ready = (state == LOAD);
  assign busy    = (state == LOAD);
  assign done    = (state == FIN);
  assign accept  = s_valid && (state == LOAD);
  assign cnt_nxt = cnt + ONE;
  assign len_ok  = (len != '0) && (len <= DEPTH_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt      <= '0;
      wren     <= 1'b0;
      addrW    <= '0;
      datain   <= '0;
      ref_len  <= '0;
      err      <= 1'b0;
`ifdef DTW_REF_LOADER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      wren <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q    <= len;
              cnt      <= '0;
              err      <= 1'b0;
              state    <= LOAD;
`ifdef DTW_REF_LOADER_CHECKSUM_EN
              checksum <= '0;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wren     <= 1'b1;
            addrW    <= cnt[ptrWid-1:0];
            datain   <= s_data;
            cnt      <= cnt_nxt;
`ifdef DTW_REF_LOADER_CHECKSUM_EN
            checksum <= checksum + s_data;
`endif
            // Reaching the requested length wins over s_last on the same beat.
            if (cnt_nxt == len_q) begin
              state   <= FIN;
              ref_len <= cnt_nxt;
            end else if (s_last) begin
              state   <= FIN;
              ref_len <= cnt_nxt;
              err     <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_core_ref_loader.sv
// tb/tb_dtw_core_ref_loader.sv - directed scoreboard bench for dtw_core_ref_loader.
module tb_dtw_core_ref_loader;
    localparam int W = 16;
    localparam int P = 4;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst, start, s_valid, s_last;
    logic [P:0]   len;
    logic [W-1:0] s_data;
    logic         s_ready, wren, busy, done, err;
    logic [P-1:0] addrW;
    logic [W-1:0] datain;
    logic [P:0]   ref_len;
`ifdef DTW_REF_LOADER_CHECKSUM_EN
    logic [W-1:0] checksum;
`endif

    int errors = 0;
    int checks = 0;
    int exp_addr = 0;
    int done_cnt = 0;
    int dc;
    bit finished = 1'b0;
    logic [P+W-1:0] sb[$];
    logic [P+W-1:0] exp_item;

    dtw_core_ref_loader #(.width(W), .ptrWid(P), .depth(D)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .addrW(addrW), .wren(wren), .datain(datain), .busy(busy), .done(done),
        .ref_len(ref_len), .err(err)
`ifdef DTW_REF_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        if (!finished) begin
            check("timeout_expired", 32'd1, 32'd0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    always @(negedge clk) begin
        if (wren) begin
            if (sb.size() == 0) begin
                check("unexpected_wren", wren, 1'b0);
            end else begin
                exp_item = sb.pop_front();
                check("wr_addr", addrW, exp_item[P+W-1:W]);
                check("wr_data", datain, exp_item[W-1:0]);
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = l[P:0];
        tick();
        start    = 1'b0;
        exp_addr = 0;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic v, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        check("s_ready_in_load", s_ready, 1'b1);
        check("busy_in_load", busy, 1'b1);
        @(posedge clk);
        #1;
        if (v) begin
            sb.push_back({exp_addr[P-1:0], d});
            exp_addr++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic end_check(input int rl, input logic e, input int dc_before);
        @(negedge clk);
        check("done_pulse", done, 1'b1);
        check("ref_len", ref_len, rl[P:0]);
        check("err", err, e);
        check("busy_fin", busy, 1'b0);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("s_ready_idle", s_ready, 1'b0);
        check("sb_drained", sb.size(), 0);
        check("done_count", done_cnt, dc_before + 1);
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_wren", wren, 1'b0);
        check("rst_addr", addrW, 4'h0);
        check("rst_data", datain, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ref_len", ref_len, 5'h0);
        check("rst_err", err, 1'b0);
        tick();

        dc = done_cnt;
        do_start(4);
        beat(16'd10, 1'b1, 1'b0);
        beat(16'd20, 1'b1, 1'b0);
        beat(16'd30, 1'b1, 1'b0);
        beat(16'd40, 1'b1, 1'b0);
        end_check(4, 1'b0, dc);

        dc = done_cnt;
        do_start(5);
        for (int i = 0; i < 5; i++) begin
            beat(16'(100 + i), 1'b1, 1'b0);
            if (i < 4) begin
                start = 1'b1;
                len   = '0;
                beat(16'hBEEF, 1'b0, 1'b0);
                start = 1'b0;
            end
        end
        end_check(5, 1'b0, dc);

        dc = done_cnt;
        do_start(8);
        beat(16'd1, 1'b1, 1'b0);
        beat(16'd2, 1'b1, 1'b0);
        beat(16'd3, 1'b1, 1'b1);
        end_check(3, 1'b1, dc);

        do_start(0);
        @(negedge clk);
        check("len0_err", err, 1'b1);
        check("len0_s_ready", s_ready, 1'b0);
        check("len0_busy", busy, 1'b0);
        check("len0_ref_len", ref_len, 5'd3);
        tick();
        do_start(D + 1);
        @(negedge clk);
        check("lenbig_err", err, 1'b1);
        check("lenbig_s_ready", s_ready, 1'b0);
        check("lenbig_ref_len", ref_len, 5'd3);
        tick();
        dc = done_cnt;
        do_start(2);
        check("err_cleared", err, 1'b0);
        beat(16'd7, 1'b1, 1'b0);
        beat(16'd8, 1'b1, 1'b0);
        end_check(2, 1'b0, dc);

        dc = done_cnt;
        do_start(D);
        for (int i = 0; i < D; i++) beat(16'(i * 3 + 1), 1'b1, i == D - 1);
        end_check(D, 1'b0, dc);

        dc = done_cnt;
        do_start(6);
        beat(16'hA1, 1'b1, 1'b0);
        beat(16'hA2, 1'b1, 1'b0);
        rst = 1'b1; s_valid = 1'b1; s_data = 16'hDEAD;
        tick();
        rst = 1'b0; s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_wren", wren, 1'b0);
            check("abort_done", done, 1'b0);
            check("abort_s_ready", s_ready, 1'b0);
        end
        check("abort_addr", addrW, 4'h0);
        check("abort_data", datain, 16'h0);
        check("abort_ref_len", ref_len, 5'h0);
        check("abort_err", err, 1'b0);
        check("abort_no_done", done_cnt, dc);
        tick();
        dc = done_cnt;
        do_start(1);
        beat(16'h55, 1'b1, 1'b0);
        end_check(1, 1'b0, dc);

`ifdef DTW_REF_LOADER_CHECKSUM_EN
        dc = done_cnt;
        do_start(2);
        beat(16'hFFFF, 1'b1, 1'b0);
        beat(16'h0002, 1'b1, 1'b0);
        end_check(2, 1'b0, dc);
        check("checksum", checksum, 16'h0001);
`endif

        check("sb_final", sb.size(), 0);
        finished = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
